// File: rtl/aclock_pkg.sv
// aclock_pkg: shared types, constants and helpers for the multi-alarm BCD clock.
//   bcd_hm_t       - BCD HH:MM (alarm value / load value)
//   bcd_time_t     - BCD HH:MM:SS time of day
//   chan_state_t   - per-channel alarm state; ST_SNOOZED exists only when
//                    ACLOCK_SNOOZE_EN is defined
//   hm_valid/hm_equal/time_inc - load validation, alarm compare, 1 s advance
package aclock_pkg;

    localparam int MAX_H = 23;
    localparam int MAX_M = 59;
    localparam int MAX_S = 59;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

    typedef struct packed {
        bcd_hm_t    hm;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RING    = 2'd1
`ifdef ACLOCK_SNOOZE_EN
        ,
        ST_SNOOZED = 2'd2
`endif
    } chan_state_t;

    function automatic int bcd_val(input logic [3:0] tens, input logic [3:0] ones);
        return int'(tens) * 10 + int'(ones);
    endfunction

    // Every digit BCD and the HH:MM value within a 24-hour day.
    function automatic logic hm_valid(input bcd_hm_t t);
        return (t.h0 <= 4'd9) && (t.m1 <= 4'd9) && (t.m0 <= 4'd9) &&
               (bcd_val({2'b00, t.h1}, t.h0) <= MAX_H) &&
               (bcd_val(t.m1, t.m0) <= MAX_M);
    endfunction

    function automatic logic hm_equal(input bcd_hm_t a, input bcd_hm_t b);
        return a == b;
    endfunction

    // Advance one second with BCD ripple carry; 23:59:59 wraps to 00:00:00.
    function automatic bcd_time_t time_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s0 != 4'd9) begin
            r.s0 = t.s0 + 4'd1;
        end else if (bcd_val(t.s1, t.s0) != MAX_S) begin
            r.s0 = 4'd0;
            r.s1 = t.s1 + 4'd1;
        end else begin
            r.s1 = 4'd0;
            r.s0 = 4'd0;
            if (t.hm.m0 != 4'd9) begin
                r.hm.m0 = t.hm.m0 + 4'd1;
            end else if (bcd_val(t.hm.m1, t.hm.m0) != MAX_M) begin
                r.hm.m0 = 4'd0;
                r.hm.m1 = t.hm.m1 + 4'd1;
            end else begin
                r.hm.m1 = 4'd0;
                r.hm.m0 = 4'd0;
                if (bcd_val({2'b00, t.hm.h1}, t.hm.h0) == MAX_H) begin
                    r.hm.h1 = 2'd0;
                    r.hm.h0 = 4'd0;
                end else if (t.hm.h0 != 4'd9) begin
                    r.hm.h0 = t.hm.h0 + 4'd1;
                end else begin
                    r.hm.h0 = 4'd0;
                    r.hm.h1 = t.hm.h1 + 2'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aclock_alarm_chan.sv
// aclock_alarm_chan: one alarm channel (alarm register, state FSM, seconds counter).
// Optional snooze is compiled in with ACLOCK_SNOOZE_EN.
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   en             - channel armed (level); low forces IDLE
//   tick, sec_zero - a second is ticking this cycle / the new time has SS=00
//   now_hm         - HH:MM of the time being ticked into
//   ld, ld_hm      - write alarm value (validated upstream), forces IDLE
//   stop, snooze   - stop / snooze request (level)
//   ring           - registered ringing flag
//   ring_next      - value ring takes at the next edge (feeds the top-level OR)
module aclock_alarm_chan
    import aclock_pkg::*;
#(
    parameter int RING_SEC = 60
`ifdef ACLOCK_SNOOZE_EN
    ,
    parameter int SNOOZE_MIN = 5
`endif
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    en,
    input  logic    tick,
    input  logic    sec_zero,
    input  bcd_hm_t now_hm,
    input  logic    ld,
    input  bcd_hm_t ld_hm,
    input  logic    stop,
`ifdef ACLOCK_SNOOZE_EN
    input  logic    snooze,
`endif
    output logic    ring,
    output logic    ring_next
);

`ifdef ACLOCK_SNOOZE_EN
    localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
`else
    localparam int SNOOZE_TICKS = 0;
`endif
    localparam int MAX_CNT = (RING_SEC > SNOOZE_TICKS) ? RING_SEC : SNOOZE_TICKS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
`ifdef ACLOCK_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);
`endif

    chan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    bcd_hm_t          alarm_reg, alarm_next;
    logic             ring_reg;
    logic             match;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            alarm_reg <= '0;
            ring_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            alarm_reg <= alarm_next;
            ring_reg  <= ring_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        alarm_next = alarm_reg;
        match      = tick && sec_zero && hm_equal(now_hm, alarm_reg);

        if (ld) begin
            alarm_next = ld_hm;
        end

        if (!en || ld || stop) begin
            state_next = ST_IDLE;
`ifdef ACLOCK_SNOOZE_EN
        end else if (snooze && (state_reg == ST_RING)) begin
            state_next = ST_SNOOZED;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (match) begin
                        state_next = ST_RING;
                    end
                end
                ST_RING: begin
                    // A fresh match while ringing restarts the ring period.
                    if (match) begin
                        cnt_next = '0;
                    end else if (tick) begin
                        if (cnt_reg == RING_LAST) begin
                            state_next = ST_IDLE;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
`ifdef ACLOCK_SNOOZE_EN
                ST_SNOOZED: begin
                    if (tick) begin
                        if (cnt_reg == SNOOZE_LAST) begin
                            state_next = ST_RING;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
`endif
                default: state_next = ST_IDLE;
            endcase
        end

        // Counter restarts on every state entry.
        if (state_next != state_reg) begin
            cnt_next = '0;
        end

        ring_next = (state_next == ST_RING);
    end

    assign ring = ring_reg;

endmodule

// File: rtl/aclock_multi.sv
// aclock_multi: 24-hour BCD clock with N_ALARMS independently armed alarms.
// Optional snooze (SNOOZE port, SNOOZE_MIN parameter) with ACLOCK_SNOOZE_EN.
// Ports:
//   clk, reset                      - clock, synchronous active-low reset
//   H_in1/H_in0/M_in1/M_in0         - BCD HH:MM load value
//   LD_time, LD_alarm, AL_SEL       - load time / load alarm[AL_SEL]
//   AL_EN                           - per-channel arm mask
//   STOP_al, SNOOZE                 - stop / snooze all ringing channels
//   Alarm, Alarm_id                 - any channel ringing / per-channel flags
//   H_out1..S_out0                  - registered BCD time of day
//   sec_tick                        - one-cycle pulse per second
//   LD_err                          - one-cycle pulse when a load is rejected
module aclock_multi
    import aclock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int N_ALARMS      = 4,
    parameter int RING_SEC      = 60
`ifdef ACLOCK_SNOOZE_EN
    ,
    parameter int SNOOZE_MIN    = 5
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          H_in1,
    input  logic [3:0]          H_in0,
    input  logic [3:0]          M_in1,
    input  logic [3:0]          M_in0,
    input  logic                LD_time,
    input  logic                LD_alarm,
    input  logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] AL_SEL,
    input  logic [N_ALARMS-1:0] AL_EN,
    input  logic                STOP_al,
`ifdef ACLOCK_SNOOZE_EN
    input  logic                SNOOZE,
`endif
    output logic                Alarm,
    output logic [N_ALARMS-1:0] Alarm_id,
    output logic [1:0]          H_out1,
    output logic [3:0]          H_out0,
    output logic [3:0]          M_out1,
    output logic [3:0]          M_out0,
    output logic [3:0]          S_out1,
    output logic [3:0]          S_out0,
    output logic                sec_tick,
    output logic                LD_err
);

    localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICKS_PER_SEC - 1);
    // One extra bit so an out-of-range index is representable for any N_ALARMS.
    localparam logic [SEL_W:0]   CHAN_LIMIT = N_ALARMS[SEL_W:0];

    logic [PRE_W-1:0]    presc_reg, presc_next;
    bcd_time_t           time_reg, time_next, time_inc_v;
    logic                tick_reg, ld_err_reg, alarm_reg;
    bcd_hm_t             ld_hm;
    logic                time_ok, alarm_ok, terminal, tick_now, sec_zero;
    logic [N_ALARMS-1:0] ring_vec, ring_next_vec;

    assign ld_hm = {H_in1, H_in0, M_in1, M_in0};

    always_comb begin
        time_ok    = LD_time && hm_valid(ld_hm);
        alarm_ok   = LD_alarm && hm_valid(ld_hm) && ({1'b0, AL_SEL} < CHAN_LIMIT);
        terminal   = (presc_reg == PRE_LAST);
        // An accepted time load swallows a coincident second tick.
        tick_now   = terminal && !time_ok;
        time_inc_v = time_inc(time_reg);
        sec_zero   = (time_inc_v.s1 == 4'd0) && (time_inc_v.s0 == 4'd0);

        presc_next = (time_ok || terminal) ? '0 : presc_reg + 1'b1;

        time_next = time_reg;
        if (time_ok) begin
            time_next = {ld_hm, 8'h00};
        end else if (tick_now) begin
            time_next = time_inc_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_reg  <= '0;
            time_reg   <= '0;
            tick_reg   <= 1'b0;
            ld_err_reg <= 1'b0;
            alarm_reg  <= 1'b0;
        end else begin
            presc_reg  <= presc_next;
            time_reg   <= time_next;
            tick_reg   <= tick_now;
            ld_err_reg <= (LD_time && !time_ok) || (LD_alarm && !alarm_ok);
            alarm_reg  <= |ring_next_vec;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ALARMS; gi++) begin : g_chan
            aclock_alarm_chan #(
                .RING_SEC   (RING_SEC)
`ifdef ACLOCK_SNOOZE_EN
                ,
                .SNOOZE_MIN (SNOOZE_MIN)
`endif
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .en        (AL_EN[gi]),
                .tick      (tick_now),
                .sec_zero  (sec_zero),
                .now_hm    (time_inc_v.hm),
                .ld        (alarm_ok && (AL_SEL == SEL_W'(gi))),
                .ld_hm     (ld_hm),
                .stop      (STOP_al),
`ifdef ACLOCK_SNOOZE_EN
                .snooze    (SNOOZE),
`endif
                .ring      (ring_vec[gi]),
                .ring_next (ring_next_vec[gi])
            );
        end
    endgenerate

    assign Alarm    = alarm_reg;
    assign Alarm_id = ring_vec;
    assign H_out1   = time_reg.hm.h1;
    assign H_out0   = time_reg.hm.h0;
    assign M_out1   = time_reg.hm.m1;
    assign M_out0   = time_reg.hm.m0;
    assign S_out1   = time_reg.s1;
    assign S_out0   = time_reg.s0;
    assign sec_tick = tick_reg;
    assign LD_err   = ld_err_reg;

endmodule

// File: tb/tb_aclock_multi.sv
// tb_aclock_multi: directed test of aclock_multi (TICKS_PER_SEC=10, N_ALARMS=3,
// RING_SEC=60, SNOOZE_MIN=5 when ACLOCK_SNOOZE_EN is defined).
// Stimulus pushes edge-stamped expected observations into a queue; a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_aclock_multi;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   H_in1;
    logic [3:0]   H_in0, M_in1, M_in0;
    logic         LD_time, LD_alarm;
    logic [1:0]   AL_SEL;
    logic [N-1:0] AL_EN;
    logic         STOP_al;
`ifdef ACLOCK_SNOOZE_EN
    logic         SNOOZE;
`endif
    logic         Alarm;
    logic [N-1:0] Alarm_id;
    logic [1:0]   H_out1;
    logic [3:0]   H_out0, M_out1, M_out0, S_out1, S_out0;
    logic         sec_tick, LD_err;

    always #5 clk = ~clk;

    aclock_multi #(
        .TICKS_PER_SEC (10),
        .N_ALARMS      (N),
        .RING_SEC      (60)
`ifdef ACLOCK_SNOOZE_EN
        ,
        .SNOOZE_MIN    (5)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .AL_SEL   (AL_SEL),
        .AL_EN    (AL_EN),
        .STOP_al  (STOP_al),
`ifdef ACLOCK_SNOOZE_EN
        .SNOOZE   (SNOOZE),
`endif
        .Alarm    (Alarm),
        .Alarm_id (Alarm_id),
        .H_out1   (H_out1),
        .H_out0   (H_out0),
        .M_out1   (M_out1),
        .M_out0   (M_out0),
        .S_out1   (S_out1),
        .S_out0   (S_out0),
        .sec_tick (sec_tick),
        .LD_err   (LD_err)
    );

    typedef struct packed {
        logic         al;
        logic [N-1:0] id;
        logic         err;
        logic         tk;
        logic [21:0]  tm;
    } obs_t;

    typedef struct {
        int    at;
        string name;
        obs_t  v;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic obs_t mk(input logic al, input logic [N-1:0] id, input logic err,
                                input logic tk, input logic [7:0] h, input logic [7:0] m,
                                input logic [7:0] s);
        obs_t o;
        o.al  = al;
        o.id  = id;
        o.err = err;
        o.tk  = tk;
        o.tm  = {h[5:4], h[3:0], m, s};
        return o;
    endfunction

    task automatic expect_at(input int at, input string name, input obs_t v);
        exp_t e;
        e.at   = at;
        e.name = name;
        e.v    = v;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs registered at edge n are compared at the following falling edge.
    always @(negedge clk) begin
        obs_t got;
        exp_t e;
        got = {Alarm, Alarm_id, LD_err, sec_tick, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
        while (sb_q.size() > 0 && sb_q[0].at <= edge_cnt) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != edge_cnt) begin
                n_bad++;
                $display("FAIL %s: compared at edge %0d, required edge %0d", e.name, edge_cnt, e.at);
            end else if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s @%0d: got al=%b id=%b err=%b tick=%b time=%h, required al=%b id=%b err=%b tick=%b time=%h",
                         e.name, edge_cnt, got.al, got.id, got.err, got.tk, got.tm,
                         e.v.al, e.v.id, e.v.err, e.v.tk, e.v.tm);
            end else begin
                $display("ok   %s @%0d: al=%b id=%b err=%b tick=%b time=%h",
                         e.name, edge_cnt, got.al, got.id, got.err, got.tk, got.tm);
            end
        end
    end

    task automatic wait_until(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic drive_hm(input logic [7:0] h, input logic [7:0] m);
        H_in1 = h[5:4];
        H_in0 = h[3:0];
        M_in1 = m[7:4];
        M_in0 = m[3:0];
    endtask

    task automatic ld_time_op(input logic [7:0] h, input logic [7:0] m);
        drive_hm(h, m);
        LD_time = 1'b1;
        @(negedge clk);
        LD_time = 1'b0;
    endtask

    task automatic ld_alarm_op(input logic [1:0] sel, input logic [7:0] h, input logic [7:0] m);
        drive_hm(h, m);
        AL_SEL   = sel;
        LD_alarm = 1'b1;
        @(negedge clk);
        LD_alarm = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP_al = 1'b1;
        @(negedge clk);
        STOP_al = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b0;
        H_in1    = '0;
        H_in0    = '0;
        M_in1    = '0;
        M_in0    = '0;
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        AL_SEL   = '0;
        AL_EN    = '0;
        STOP_al  = 1'b0;
`ifdef ACLOCK_SNOOZE_EN
        SNOOZE   = 1'b0;
`endif
        expect_at(2, "reset_state", mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Ten seconds of free running from reset.
        n = edge_cnt;
        expect_at(n + 9,   "pre_first_tick", mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
        expect_at(n + 10,  "first_tick",     mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01));
        expect_at(n + 99,  "sec_09",         mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h09));
        expect_at(n + 100, "sec_10_tick",    mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 8'h00, 8'h10));
        expect_at(n + 101, "sec_10_hold",    mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10));
        wait_until(n + 101);

        // Midnight wrap.
        n = edge_cnt;
        expect_at(n + 1,   "ld_2359",   mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h23, 8'h59, 8'h00));
        expect_at(n + 591, "t_235959",  mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59));
        expect_at(n + 600, "hold_2359", mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h23, 8'h59, 8'h59));
        expect_at(n + 601, "wrap_0000", mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00));
        ld_time_op(8'h23, 8'h59);
        wait_until(n + 601);

        // Alarms 0,1,2 all at 10:20; channel 1 disarmed. Ring, then auto-stop.
        ld_alarm_op(2'd0, 8'h10, 8'h20);
        ld_alarm_op(2'd1, 8'h10, 8'h20);
        ld_alarm_op(2'd2, 8'h10, 8'h20);
        AL_EN = 3'b101;
        n = edge_cnt;
        expect_at(n + 1,    "ld_1019",      mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h10, 8'h19, 8'h00));
        expect_at(n + 600,  "pre_match",    mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h10, 8'h19, 8'h59));
        expect_at(n + 601,  "match_1020",   mk(1'b1, 3'b101, 1'b0, 1'b1, 8'h10, 8'h20, 8'h00));
        expect_at(n + 602,  "ringing",      mk(1'b1, 3'b101, 1'b0, 1'b0, 8'h10, 8'h20, 8'h00));
        expect_at(n + 1191, "ring_102059",  mk(1'b1, 3'b101, 1'b0, 1'b1, 8'h10, 8'h20, 8'h59));
        expect_at(n + 1200, "ring_last",    mk(1'b1, 3'b101, 1'b0, 1'b0, 8'h10, 8'h20, 8'h59));
        expect_at(n + 1201, "auto_stop",    mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h10, 8'h21, 8'h00));
        ld_time_op(8'h10, 8'h19);
        wait_until(n + 1201);

        // STOP_al at 10:20:05.
        n = edge_cnt;
        expect_at(n + 651, "ring_102005", mk(1'b1, 3'b101, 1'b0, 1'b1, 8'h10, 8'h20, 8'h05));
        expect_at(n + 652, "stop_clears", mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h10, 8'h20, 8'h05));
        expect_at(n + 701, "stay_idle",   mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h10, 8'h20, 8'h10));
        ld_time_op(8'h10, 8'h19);
        wait_until(n + 651);
        pulse_stop();
        wait_until(n + 701);

        // Disarming a ringing channel drops only that channel.
        n = edge_cnt;
        expect_at(n + 601, "rematch",     mk(1'b1, 3'b101, 1'b0, 1'b1, 8'h10, 8'h20, 8'h00));
        expect_at(n + 612, "disarm_ch2",  mk(1'b1, 3'b001, 1'b0, 1'b0, 8'h10, 8'h20, 8'h01));
        expect_at(n + 613, "stop_rest",   mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h10, 8'h20, 8'h01));
        ld_time_op(8'h10, 8'h19);
        wait_until(n + 611);
        AL_EN = 3'b001;
        @(negedge clk);
        AL_EN   = 3'b101;
        STOP_al = 1'b1;
        @(negedge clk);
        STOP_al = 1'b0;

        // Rejected loads leave state alone; a valid load suppresses a coincident tick.
        n = edge_cnt;
        expect_at(n + 1,  "ld_1234",       mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00));
        expect_at(n + 2,  "err_h24",       mk(1'b0, 3'b000, 1'b1, 1'b0, 8'h12, 8'h34, 8'h00));
        expect_at(n + 3,  "err_m60",       mk(1'b0, 3'b000, 1'b1, 1'b0, 8'h12, 8'h34, 8'h00));
        expect_at(n + 4,  "err_sel",       mk(1'b0, 3'b000, 1'b1, 1'b0, 8'h12, 8'h34, 8'h00));
        expect_at(n + 5,  "err_nonbcd",    mk(1'b0, 3'b000, 1'b1, 1'b0, 8'h12, 8'h34, 8'h00));
        expect_at(n + 6,  "err_clear",     mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00));
        expect_at(n + 11, "tick_after_err", mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h12, 8'h34, 8'h01));
        expect_at(n + 21, "ld_suppress",   mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00));
        expect_at(n + 31, "tick_after_ld", mk(1'b0, 3'b000, 1'b0, 1'b1, 8'h12, 8'h00, 8'h01));
        ld_time_op(8'h12, 8'h34);
        ld_time_op(8'h24, 8'h00);
        ld_time_op(8'h12, 8'h60);
        ld_alarm_op(2'd3, 8'h10, 8'h20);
        ld_alarm_op(2'd1, 8'h1A, 8'h00);
        wait_until(n + 20);
        ld_time_op(8'h12, 8'h00);
        wait_until(n + 31);

`ifdef ACLOCK_SNOOZE_EN
        // Snooze at 10:20:03, re-ring five minutes later, then stop.
        n = edge_cnt;
        expect_at(n + 601,  "sn_match",   mk(1'b1, 3'b101, 1'b0, 1'b1, 8'h10, 8'h20, 8'h00));
        expect_at(n + 631,  "sn_102003",  mk(1'b1, 3'b101, 1'b0, 1'b1, 8'h10, 8'h20, 8'h03));
        expect_at(n + 632,  "snoozed",    mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h10, 8'h20, 8'h03));
        expect_at(n + 3630, "sn_102502",  mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h10, 8'h25, 8'h02));
        expect_at(n + 3631, "re_ring",    mk(1'b1, 3'b101, 1'b0, 1'b1, 8'h10, 8'h25, 8'h03));
        expect_at(n + 3632, "sn_stopped", mk(1'b0, 3'b000, 1'b0, 1'b0, 8'h10, 8'h25, 8'h03));
        ld_time_op(8'h10, 8'h19);
        wait_until(n + 631);
        SNOOZE = 1'b1;
        @(negedge clk);
        SNOOZE = 1'b0;
        wait_until(n + 3631);
        pulse_stop();
        wait_until(n + 3632);
`endif

        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aclock_multi.md
# aclock_multi

Parametrised multi-alarm BCD clock, the next generation of the single-alarm `Aclock`. It keeps a 24-hour HH:MM:SS time of day from a fast system clock via a prescaler and supports `N_ALARMS` independently armed alarm channels. Each channel has auto-stop and, optionally, snooze. It sits between the front-panel input logic and the display and buzzer drivers.

## Interface
- `TICKS_PER_SEC`, 10: `clk` cycles per second, ≥1.
- `N_ALARMS`, 4: alarm channels, 1..16.
- `RING_SEC`, 60: seconds a channel rings before auto-stop.
- `SNOOZE_MIN`, 5: snooze length in minutes (snooze build only).
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `H_in1`  in  2 / `H_in0`  in  4 / `M_in1`  in  4 / `M_in0`  in  4: BCD HH:MM load value.
- `LD_time`  in  1: load time from inputs.
- `LD_alarm`  in  1: load alarm `AL_SEL` from inputs.
- `AL_SEL`  in  max(1,$clog2(N_ALARMS)): alarm channel index.
- `AL_EN`  in  N_ALARMS: per-channel arm mask, level.
- `STOP_al`  in  1: stop all ringing channels, level.
- `SNOOZE`  in  1: snooze all ringing channels, level (snooze build only).
- `Alarm`  out  1: OR of ringing channels.
- `Alarm_id`  out  N_ALARMS: per-channel ringing flags.
- `H_out1`  out  2 / `H_out0` `M_out1` `M_out0` `S_out1` `S_out0`  out  4: BCD time.
- `sec_tick`  out  1: one-cycle pulse per second.
- `LD_err`  out  1: one-cycle pulse when a load is rejected.

## Operation
- Reset (`reset`=0 at an edge) sets: time 00:00:00, prescaler 0, all alarms 00:00, all channels IDLE, all outputs 0.
- Prescaler counts 0..TICKS_PER_SEC-1. At the terminal count, `sec_tick` pulses and time advances one second.
- BCD carry: S 59→00 carries to M, M 59→00 carries to H, 23:59:59→00:00:00.
- `LD_time`: loads HH:MM, sets S=00 and prescaler=0, suppresses any tick in the same cycle.
- `LD_alarm`: writes alarm[`AL_SEL`] and forces that channel to IDLE.
- Validity: a load is rejected and `LD_err` pulses if any digit is non-BCD, H>23, M>59, or `AL_SEL`≥N_ALARMS. A rejected load changes no state.
- `LD_time` and `LD_alarm` in the same cycle both execute, each validated independently.
- Match: on a `sec_tick` whose new time is HH:MM:00 equal to alarm[i] with `AL_EN[i]`=1, channel i goes IDLE→RING. Loading a time never triggers a match.
- Per-channel FSM:
  - IDLE→RING on match.
  - RING→IDLE on `STOP_al`, or after RING_SEC ticks in RING.
  - RING→SNOOZED on `SNOOZE`; SNOOZED→RING after SNOOZE_MIN×60 ticks.
  - Any state→IDLE when `AL_EN[i]`=0.
- Priority, highest first: reset, `AL_EN` low, `STOP_al`, `SNOOZE`, match or expiry.
- `STOP_al` also cancels SNOOZED channels.
- A match on a channel already in RING restarts its ring counter.
- One seconds counter per channel, width $clog2(max(RING_SEC, SNOOZE_MIN×60)+1), cleared on every state entry.

## Timing
- All outputs are registered.
- Time outputs update the cycle after the terminal-count edge. `sec_tick` is high in that same cycle.
- `Alarm` and `Alarm_id` rise in the cycle after the tick that reaches HH:MM:00, i.e. aligned with the new time outputs.
- `STOP_al` or `SNOOZE` sampled at edge k clears `Alarm` at edge k, so it is low from cycle k+1.
- Load takes effect at the sampling edge; outputs show the loaded value next cycle. `LD_err` is aligned with that cycle.
- Reset mid-ring drops `Alarm` the cycle after the reset edge.

## Configuration
- `ACLOCK_SNOOZE_EN` defined: `SNOOZE` port, `SNOOZE_MIN` parameter and the SNOOZED state exist.
- `ACLOCK_SNOOZE_EN` undefined: the port, parameter and state are removed; the FSM is IDLE/RING only and all other behaviour is identical.

## Structure
- Package `aclock_pkg`:
  - BCD time struct typedef.
  - Channel state enum.
  - Constants `MAX_H`=23, `MAX_M`=59, `MAX_S`=59.
  - BCD validity and compare functions.
- Sub-module `aclock_alarm_chan`: alarm register, FSM and seconds counter, instantiated N_ALARMS times in a generate loop.
- Top level holds prescaler, time counter, load decode and output OR.

## Test plan
- Reset then 10 s of ticks (TICKS_PER_SEC=10) → `S_out`=10, `sec_tick` pulses every 10 cycles.
- LD_time 23:59, run 60 s → wraps to 00:00:00, H_out1=0, H_out0=0.
- Alarm 0 = 10:20, alarm 2 = 10:20, AL_EN=0101, LD_time 10:19, run 60 s → `Alarm_id`=0101 one cycle after 10:20:00 appears.
- Ringing, no stop, RING_SEC=60 → `Alarm` falls at 10:21:00. Repeat with `STOP_al` at 10:20:05 → `Alarm` low next cycle.
- Snooze build, `SNOOZE` at 10:20:03 → `Alarm` low, re-rings at 10:25:03, `STOP_al` → IDLE.
- LD_time H_in1=2, H_in0=4 or M_in1=6 → `LD_err` pulse, time unchanged. LD_alarm with `AL_SEL`=N_ALARMS → `LD_err`.
